// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: handshake and key bus between the AES request logic
// (master) and the round sequencer (slave). Widths follow the round count NR
// and the round-key width KW.
interface aes_round_ctrl_if #(
  parameter int NR = 10,
  parameter int KW = 128
);
  logic                  iStart;
  logic                  iAbort;
  logic                  iDecrypt;
  logic [(NR+1)*KW-1:0]  iRoundKeys;
  logic                  oReady;
  logic                  oBusy;
  logic                  oLoad;
  logic                  oRoundEn;
  logic                  oFinal;
  logic                  oDone;
  logic [3:0]            oRound;
  logic [KW-1:0]         oRoundKey;

  modport master (
    output iStart, iAbort, iDecrypt, iRoundKeys,
    input  oReady, oBusy, oLoad, oRoundEn, oFinal, oDone, oRound, oRoundKey
  );

  modport slave (
    input  iStart, iAbort, iDecrypt, iRoundKeys,
    output oReady, oBusy, oLoad, oRoundEn, oFinal, oDone, oRound, oRoundKey
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer. Steps the single-round
// datapath through the initial AddRoundKey, NR-1 full rounds and the final
// round, and selects the matching round key from the flattened key bus.
// Optional feature macro: AES_DECRYPT_EN (honour iDecrypt, reverse key order).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for iStart, oReady=1
//   S_LOAD  | datapath loads block XOR round key 0 (oRound=0)
//   S_ROUND | full round 1..NR-1 with oRoundEn
//   S_FINAL | last round (no MixColumns), oRound=NR
//   S_DONE  | one-cycle oDone; a new iStart goes straight to S_LOAD
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input logic           iClk,
  input logic           iRst,
  aes_round_ctrl_if.slave bus
);

  localparam logic [3:0] NR4       = 4'(NR);
  localparam logic [3:0] LAST_FULL = NR4 - 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] round_q, round_nxt;
  logic       dir_q, dir_nxt;
  logic       req_dir;
  logic [3:0] key_idx;

`ifdef AES_DECRYPT_EN
  assign req_dir = bus.iDecrypt;
`else
  // Direction request is read but masked, so the direction flop stays at 0.
  assign req_dir = 1'b0 & bus.iDecrypt;
`endif

  // State, round counter and latched direction registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= S_IDLE;
      round_q <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      dir_q   <= dir_nxt;
    end
  end

  // Next-state, round counter and direction update; abort beats start.
  always_comb begin
    state_nxt = state;
    round_nxt = round_q;
    dir_nxt   = dir_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.iStart && !bus.iAbort) begin
          state_nxt = S_LOAD;
          round_nxt = 4'd0;
          dir_nxt   = req_dir;
        end else begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
        end
      end
      S_LOAD: begin
        if (bus.iAbort) begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
        end else begin
          round_nxt = 4'd1;
          state_nxt = (NR4 == 4'd1) ? S_FINAL : S_ROUND;
        end
      end
      S_ROUND: begin
        if (bus.iAbort) begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
        end else begin
          round_nxt = round_q + 4'd1;
          state_nxt = (round_q < LAST_FULL) ? S_ROUND : S_FINAL;
        end
      end
      S_FINAL: begin
        if (bus.iAbort) begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        round_nxt = 4'd0;
      end
    endcase
  end

  // Control strobes are pure decodes of the registered state.
  always_comb begin
    bus.oReady   = (state == S_IDLE) || (state == S_DONE);
    bus.oBusy    = (state == S_LOAD) || (state == S_ROUND) || (state == S_FINAL);
    bus.oLoad    = (state == S_LOAD);
    bus.oRoundEn = (state == S_ROUND) || (state == S_FINAL);
    bus.oFinal   = (state == S_FINAL);
    bus.oDone    = (state == S_DONE);
    bus.oRound   = round_q;
  end

  // Key mux: decryption walks the schedule backwards from key NR.
  always_comb begin
    key_idx       = dir_q ? (NR4 - round_q) : round_q;
    bus.oRoundKey = bus.iRoundKeys[KW*key_idx +: KW];
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int KW = 128;
`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  aes_round_ctrl_if #(.NR(NR), .KW(KW)) bus ();
  aes_round_ctrl #(.NR(NR), .KW(KW)) dut (.iClk(clk), .iRst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expanded schedule of key 000102030405060708090a0b0c0d0e0f
  logic [KW-1:0] fips [0:NR] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  // Reference model: an operation is a position counted from LOAD (0);
  // positions 1..NR are rounds, NR is the final one, NR+1 is the done cycle.
  bit m_active = 1'b0;
  int m_pos    = 0;
  bit m_dir    = 1'b0;

  typedef struct {
    bit            start;
    bit            dec;
    logic [5:0]    ctl;   // {ready, busy, load, round_en, final, done}
    logic [3:0]    rnd;
    logic [KW-1:0] key;
  } vec_t;
  vec_t tbl [NR+2];

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_ctl();
    return {bus.oReady, bus.oBusy, bus.oLoad, bus.oRoundEn, bus.oFinal, bus.oDone};
  endfunction

  task automatic load_fips_keys();
    for (int k = 0; k <= NR; k++) bus.iRoundKeys[KW*k +: KW] = fips[k];
  endtask

  task automatic random_keys();
    for (int w = 0; w < (NR+1)*KW/32; w++) bus.iRoundKeys[32*w +: 32] = $urandom;
  endtask

  task automatic model_compare();
    bit busy;
    logic [5:0] exp_ctl;
    int idx;
    busy    = m_active && (m_pos <= NR);
    exp_ctl = {!busy, busy, m_active && m_pos == 0, m_active && m_pos >= 1 && m_pos <= NR,
               m_active && m_pos == NR, m_active && m_pos == NR + 1};
    check("ctrl", KW'(dut_ctl()), KW'(exp_ctl));
    if (busy) begin
      idx = m_dir ? NR - m_pos : m_pos;
      check("round", KW'(bus.oRound), KW'(m_pos));
      check("key", bus.oRoundKey, bus.iRoundKeys[KW*idx +: KW]);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic cycle(input bit s, input bit a, input bit d, input bit r);
    bus.iStart   = s;
    bus.iAbort   = a;
    bus.iDecrypt = d;
    rst          = r;
    @(posedge clk);
    if (r) m_active = 1'b0;
    else if (m_active && m_pos <= NR) begin
      if (a) m_active = 1'b0;
      else m_pos++;
    end else if (s && !a) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_dir    = DEC_EN ? d : 1'b0;
    end else m_active = 1'b0;
    #1;
    model_compare();
  endtask

  task automatic fill_table(input bit dec);
    for (int i = 0; i < NR + 2; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].dec   = dec;
      tbl[i].rnd   = 4'(i);
      tbl[i].key   = (DEC_EN && dec) ? fips[NR-i] : fips[(i > NR) ? NR : i];
      if (i == 0)       tbl[i].ctl = 6'b011000;
      else if (i < NR)  tbl[i].ctl = 6'b010100;
      else if (i == NR) tbl[i].ctl = 6'b010110;
      else              tbl[i].ctl = 6'b100001;
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < NR + 2; i++) begin
      cycle(tbl[i].start, 1'b0, tbl[i].dec, 1'b0);
      check({tag, "_ctl"}, KW'(dut_ctl()), KW'(tbl[i].ctl));
      if (i <= NR) begin
        check({tag, "_round"}, KW'(bus.oRound), KW'(tbl[i].rnd));
        check({tag, "_key"}, bus.oRoundKey, tbl[i].key);
      end
    end
  endtask

  initial begin
    int t_done;
    int n_done;
    int last_done;

    bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iDecrypt = 1'b0; rst = 1'b1;
    load_fips_keys();

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_ctl", KW'(dut_ctl()), KW'(6'b100000));
    check("reset_round", KW'(bus.oRound), KW'(0));
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Encrypt sequence
    fill_table(1'b0);
    run_table("enc");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Decrypt request (reverse order only when the feature is built in)
    fill_table(1'b1);
    run_table("dec");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Start pulse at round 4 is ignored; done stays at cycle 12
    t_done = -1; n_done = 0;
    for (int k = 1; k <= 15; k++) begin
      cycle(k == 1 || k == 6, 1'b0, 1'b0, 1'b0);
      if (bus.oDone) begin
        n_done++;
        if (t_done < 0) t_done = k;
      end
    end
    check("ignore_done_cycle", KW'(t_done), KW'(12));
    check("ignore_done_count", KW'(n_done), KW'(1));

    // Abort at round 5
    for (int k = 1; k <= 6; k++) cycle(k == 1, 1'b0, 1'b0, 1'b0);
    check("abort_pre_round", KW'(bus.oRound), KW'(5));
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_ctl", KW'(dut_ctl()), KW'(6'b100000));
    n_done = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.oDone) n_done++;
    end
    check("abort_no_done", KW'(n_done), KW'(0));

    // Abort and start together in IDLE: abort wins
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_start_idle", KW'(dut_ctl()), KW'(6'b100000));

    // Back-to-back with iStart held high
    n_done = 0; last_done = 0;
    for (int k = 1; k <= 37; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.oDone) begin
        n_done++;
        check("b2b_spacing", KW'(k - last_done), KW'(12));
        last_done = k;
      end
    end
    check("b2b_done_count", KW'(n_done), KW'(3));
    for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during round 7, then a full normal sequence
    for (int k = 1; k <= 8; k++) cycle(k == 1, 1'b0, 1'b0, 1'b0);
    check("rst_pre_round", KW'(bus.oRound), KW'(7));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_ctl", KW'(dut_ctl()), KW'(6'b100000));
    check("rst_round", KW'(bus.oRound), KW'(0));
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.oDone) n_done++;
    end
    check("rst_no_done", KW'(n_done), KW'(0));
    fill_table(1'b0);
    run_table("post_rst");

    // Randomized traffic with changing keys against the model
    for (int k = 0; k < 3000; k++) begin
      random_keys();
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
            1'($urandom), $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
